// File: rtl/kb_pkg.sv
// kb_pkg: scancode constants, arrow codes and FIFO entry layout shared by the keyboard path
package kb_pkg;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] ASC_UP    = 8'h80;
    localparam logic [7:0] ASC_DOWN  = 8'h81;
    localparam logic [7:0] ASC_LEFT  = 8'h82;
    localparam logic [7:0] ASC_RIGHT = 8'h83;
    localparam int E_CTRL  = 15;
    localparam int E_SHIFT = 14;
    localparam int E_E0    = 13;
    function automatic logic [7:0] arrow_ascii(input logic [7:0] code);
        return code == 8'h75 ? ASC_UP   :
               code == 8'h72 ? ASC_DOWN :
               code == 8'h6B ? ASC_LEFT :
               code == 8'h74 ? ASC_RIGHT : 8'h00;
    endfunction
endpackage

// File: rtl/kb_ascii_rom.sv
// kb_ascii_rom: set-2 make code to ASCII lookup; letters come out uppercase iff shift, 0x00 when unmapped
module kb_ascii_rom (
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] ascii
);
    logic [7:0] lo, hi;
    // each code carries its unshifted and shifted glyph
    always_comb begin
        {lo, hi} = 16'h0000;
        case (code)
            8'h1C: {lo, hi} = "aA";   8'h32: {lo, hi} = "bB";
            8'h21: {lo, hi} = "cC";   8'h23: {lo, hi} = "dD";
            8'h24: {lo, hi} = "eE";   8'h2B: {lo, hi} = "fF";
            8'h34: {lo, hi} = "gG";   8'h33: {lo, hi} = "hH";
            8'h43: {lo, hi} = "iI";   8'h3B: {lo, hi} = "jJ";
            8'h42: {lo, hi} = "kK";   8'h4B: {lo, hi} = "lL";
            8'h3A: {lo, hi} = "mM";   8'h31: {lo, hi} = "nN";
            8'h44: {lo, hi} = "oO";   8'h4D: {lo, hi} = "pP";
            8'h15: {lo, hi} = "qQ";   8'h2D: {lo, hi} = "rR";
            8'h1B: {lo, hi} = "sS";   8'h2C: {lo, hi} = "tT";
            8'h3C: {lo, hi} = "uU";   8'h2A: {lo, hi} = "vV";
            8'h1D: {lo, hi} = "wW";   8'h22: {lo, hi} = "xX";
            8'h35: {lo, hi} = "yY";   8'h1A: {lo, hi} = "zZ";
            8'h16: {lo, hi} = "1!";   8'h1E: {lo, hi} = "2@";
            8'h26: {lo, hi} = "3#";   8'h25: {lo, hi} = "4$";
            8'h2E: {lo, hi} = "5%";   8'h36: {lo, hi} = "6^";
            8'h3D: {lo, hi} = "7&";   8'h3E: {lo, hi} = "8*";
            8'h46: {lo, hi} = "9(";   8'h45: {lo, hi} = "0)";
            8'h0E: {lo, hi} = "`~";   8'h4E: {lo, hi} = "-_";
            8'h55: {lo, hi} = "=+";   8'h54: {lo, hi} = "[{";
            8'h5B: {lo, hi} = "]}";   8'h5D: {lo, hi} = "\\|";
            8'h4C: {lo, hi} = ";:";   8'h52: {lo, hi} = "'\"";
            8'h41: {lo, hi} = ",<";   8'h49: {lo, hi} = ".>";
            8'h4A: {lo, hi} = "/?";
            8'h5A: {lo, hi} = 16'h0D0D;
            8'h66: {lo, hi} = 16'h0808;
            8'h29: {lo, hi} = 16'h2020;
            8'h76: {lo, hi} = 16'h1B1B;
            8'h0D: {lo, hi} = 16'h0909;
            default: {lo, hi} = 16'h0000;
        endcase
    end
    assign ascii = shift ? hi : lo;
endmodule

// File: rtl/kb_ascii_fifo.sv
// kb_ascii_fifo: scancode capture, modifier tracking, ASCII translation and FWFT output FIFO
module kb_ascii_fifo import kb_pkg::*; #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kb_ready,
    input  logic        kb_e0,
    input  logic        kb_break,
    input  logic [7:0]  kb_code,
    input  logic        rd_en,
    input  logic        clr_ovf,
    output logic [15:0] rd_data,
    output logic        kb_empty,
    output logic        kb_full,
    output logic        overflow,
    output logic        caps_led
);
    logic              kb_ready_d, ev, v1, e0_1, brk_1;
    logic [7:0]        code_1, rom_ascii, ascii;
    logic              shift_l, shift_r, ctrl, caps, caps_held;
    logic              shift_l_n, shift_r_n, ctrl_n, caps_n, caps_held_n;
    logic              dv, is_ls, is_rs, is_ctrl, is_caps, is_mod, shift_eff, letter, push;
    logic              pop, acc;
    logic [15:0]       word;
    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count;

    assign ev = kb_ready & ~kb_ready_d;

    // one capture per rising edge of the receiver's level-held ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kb_ready_d <= 1'b0;
            v1         <= 1'b0;
            code_1     <= '0;
            e0_1       <= 1'b0;
            brk_1      <= 1'b0;
        end else begin
            kb_ready_d <= kb_ready;
            v1         <= ev;
            if (ev) begin
                code_1 <= kb_code;
                e0_1   <= kb_e0;
                brk_1  <= kb_break;
            end
        end
    end

    assign dv        = v1 && code_1 != SC_E0 && code_1 != SC_BREAK;
    assign is_ls     = !e0_1 && code_1 == SC_LSHIFT;
    assign is_rs     = !e0_1 && code_1 == SC_RSHIFT;
    assign is_ctrl   = code_1 == SC_CTRL;
    assign is_caps   = !e0_1 && code_1 == SC_CAPS;
    assign is_mod    = is_ls | is_rs | is_ctrl | is_caps;
    assign shift_eff = shift_l | shift_r;

    kb_ascii_rom u_rom (.code(code_1), .shift(shift_eff), .ascii(rom_ascii));

    assign letter = (rom_ascii | 8'h20) >= "a" && (rom_ascii | 8'h20) <= "z";
    assign ascii  = e0_1   ? arrow_ascii(code_1) :
                    letter ? {rom_ascii[7:6], ~(shift_eff ^ caps), rom_ascii[4:0]} : rom_ascii;
    assign push   = dv && !is_mod && !brk_1 && ascii != 8'h00;

    // next modifier state; caps toggles only on the first make of a held key
    always_comb begin
        shift_l_n   = dv && is_ls ? ~brk_1 : shift_l;
        shift_r_n   = dv && is_rs ? ~brk_1 : shift_r;
        ctrl_n      = dv && is_ctrl ? ~brk_1 : ctrl;
        caps_n      = dv && is_caps && !brk_1 && !caps_held ? ~caps : caps;
        caps_held_n = dv && is_caps ? ~brk_1 : caps_held;
    end

    // modifier state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {shift_l, shift_r, ctrl, caps, caps_held} <= '0;
        end else begin
            {shift_l, shift_r, ctrl, caps, caps_held} <= {shift_l_n, shift_r_n, ctrl_n, caps_n, caps_held_n};
        end
    end

    // assemble the pushed entry from qualifier bits and character
    always_comb begin
        word          = '0;
        word[E_CTRL]  = ctrl;
        word[E_SHIFT] = shift_eff;
        word[E_E0]    = e0_1;
        word[7:0]     = ascii;
    end

    assign pop      = rd_en && !kb_empty;
    assign acc      = push && (!kb_full || pop);
    assign kb_empty = count == '0;
    assign kb_full  = count == (ADDR_W+1)'(DEPTH);
    assign rd_data  = kb_empty ? 16'h0000 : mem[rd_ptr];
    assign caps_led = caps;

    // storage needs no reset: reads are masked while empty
    always_ff @(posedge clk) begin
        if (acc) mem[wr_ptr] <= word;
    end

    // pointers, occupancy and sticky overflow; a full FIFO may still accept when popping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count    <= count + (ADDR_W+1)'(acc) - (ADDR_W+1)'(pop);
            overflow <= (push && !acc) || (overflow && !clr_ovf);
        end
    end
endmodule

// File: tb/tb_kb_ascii_fifo.sv
// tb_kb_ascii_fifo: directed scancode sequences against hand-computed FIFO entries
module tb_kb_ascii_fifo;
    logic        clk = 1'b0, rst = 1'b0;
    logic        kb_ready = 1'b0, kb_e0 = 1'b0, kb_break = 1'b0;
    logic [7:0]  kb_code = 8'h00;
    logic        rd_en = 1'b0, clr_ovf = 1'b0;
    logic [15:0] rd_data;
    logic        kb_empty, kb_full, overflow, caps_led;
    int          n_chk = 0, n_pass = 0;

    kb_ascii_fifo dut (
        .clk(clk), .rst(rst), .kb_ready(kb_ready), .kb_e0(kb_e0), .kb_break(kb_break),
        .kb_code(kb_code), .rd_en(rd_en), .clr_ovf(clr_ovf), .rd_data(rd_data),
        .kb_empty(kb_empty), .kb_full(kb_full), .overflow(overflow), .caps_led(caps_led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic key(input logic [7:0] c, input logic e, input logic b, input int hold);
        @(negedge clk);
        kb_code = c; kb_e0 = e; kb_break = b; kb_ready = 1'b1;
        repeat (hold) @(negedge clk);
        kb_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk); rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [15:0] exp);
        chk(tag, rd_data, exp);
        pop();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data", rd_data, 16'h0000);
        chk("rst_empty", 16'(kb_empty), 16'h1);
        chk("rst_full", 16'(kb_full), 16'h0);
        chk("rst_ovf", 16'(overflow), 16'h0);
        chk("rst_caps", 16'(caps_led), 16'h0);
        rst = 1'b1;

        key(8'h1C, 0, 0, 200);
        pop_chk("a_long", 16'h0061);
        chk("a_once_empty", 16'(kb_empty), 16'h1);
        chk("a_once_data", rd_data, 16'h0000);
        pop();
        chk("pop_empty_data", rd_data, 16'h0000);

        key(8'h12, 0, 0, 4);
        key(8'h1C, 0, 0, 4);
        key(8'h12, 0, 1, 4);
        key(8'h1C, 0, 0, 4);
        pop_chk("shift_A", 16'h4041);
        pop_chk("unshift_a", 16'h0061);
        chk("shift_empty", 16'(kb_empty), 16'h1);

        key(8'h58, 0, 0, 4);
        key(8'h58, 0, 0, 4);
        key(8'h58, 0, 1, 4);
        key(8'h1C, 0, 0, 4);
        chk("caps_on", 16'(caps_led), 16'h1);
        pop_chk("caps_A", 16'h0041);
        key(8'h58, 0, 0, 4);
        key(8'h58, 0, 1, 4);
        key(8'h1C, 0, 0, 4);
        chk("caps_off", 16'(caps_led), 16'h0);
        pop_chk("caps_a", 16'h0061);

        key(8'h75, 1, 0, 4);
        pop_chk("e0_up", 16'h2080);
        key(8'h1F, 1, 0, 4);
        key(8'h1C, 0, 1, 4);
        chk("discard_empty", 16'(kb_empty), 16'h1);

        for (int i = 0; i < 17; i++) key(8'h29, 0, 0, 3);
        chk("full", 16'(kb_full), 16'h1);
        chk("ovf_set", 16'(overflow), 16'h1);
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        chk("ovf_clr", 16'(overflow), 16'h0);
        @(negedge clk); kb_code = 8'h29; kb_e0 = 1'b0; kb_break = 1'b0; kb_ready = 1'b1;
        @(negedge clk); rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0; kb_ready = 1'b0;
        chk("pushpop_full", 16'(kb_full), 16'h1);
        chk("pushpop_ovf", 16'(overflow), 16'h0);
        for (int i = 0; i < 16; i++) pop_chk($sformatf("space%0d", i), 16'h0020);
        chk("drain_empty", 16'(kb_empty), 16'h1);

        key(8'h58, 0, 0, 4);
        key(8'h58, 0, 1, 4);
        for (int i = 0; i < 3; i++) key(8'h1C, 0, 0, 4);
        chk("pre_rst_data", rd_data, 16'h0041);
        @(negedge clk); kb_code = 8'h1C; kb_ready = 1'b1;
        @(posedge clk); #1 rst = 1'b0; kb_ready = 1'b0;
        #1;
        chk("mid_rst_data", rd_data, 16'h0000);
        chk("mid_rst_empty", 16'(kb_empty), 16'h1);
        chk("mid_rst_full", 16'(kb_full), 16'h0);
        chk("mid_rst_ovf", 16'(overflow), 16'h0);
        chk("mid_rst_caps", 16'(caps_led), 16'h0);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 16'(kb_empty), 16'h1);
        key(8'h1C, 0, 0, 4);
        pop_chk("post_rst_a", 16'h0061);
        chk("post_rst_empty", 16'(kb_empty), 16'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/kb_ascii_fifo.md
# kb_ascii_fifo

Downstream consumer of the PS/2 keyboard receiver: takes each completed scancode (with its E0/break qualifiers), tracks modifier state, and translates make codes to ASCII. Results go into a small first-word-fall-through FIFO that the CPU memory-mapped I/O path polls and pops. Modifier keys, break codes and unmapped keys are filtered out here, so the CPU only ever sees printable or control characters and arrow keys.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- ADDR_W, 4, log2(DEPTH)
- clk  in  1  system clock, same domain as the keyboard receiver
- rst  in  1  asynchronous, active-low reset
- kb_ready  in  1  receiver's data_ready; a level held high for many cycles per scancode
- kb_e0  in  1  receiver's e0_flag, valid while kb_ready high
- kb_break  in  1  receiver's break_flag, valid while kb_ready high
- kb_code  in  8  receiver's scancode byte, valid while kb_ready high
- rd_en  in  1  pop head entry (one-cycle pulse per pop)
- clr_ovf  in  1  clear sticky overflow
- rd_data  out  16  head entry {ctrl, shift_eff, e0, 5'b0, ascii[7:0]}; 16'h0000 when empty
- kb_empty  out  1  FIFO empty
- kb_full  out  1  FIFO full
- overflow  out  1  sticky; set when a translated key is dropped
- caps_led  out  1  current Caps Lock state

## Operation
- Event detect: register kb_ready_d (reset 0); event = kb_ready & ~kb_ready_d. Exactly one event per scancode regardless of level duration.
- Stage 1 (capture): on event, latch kb_code, kb_e0, kb_break; set v1.
- Stage 2 (decode, when v1):
  - Modifiers, never pushed: 0x12 L-shift and 0x59 R-shift (make sets, break clears own bit); 0x14 Ctrl, with or without E0 (make sets, break clears).
  - Caps Lock 0x58: make toggles caps only if caps_held is 0, then sets caps_held; break clears caps_held. Typematic repeat does not re-toggle.
  - Any other break code: discarded.
  - E0 makes: 0x75→0x80 (up), 0x72→0x81 (down), 0x6B→0x82 (left), 0x74→0x83 (right). All other E0 codes: discarded.
  - Non-E0 makes go through the kb_ascii_rom lookup using shift_eff = shift_l|shift_r.
    - Letters A–Z: uppercase iff shift_eff XOR caps.
    - Digits and punctuation: shifted glyph iff shift_eff.
    - Fixed codes: 0x5A→0x0D, 0x66→0x08, 0x29→0x20, 0x76→0x1B, 0x0D→0x09.
    - ROM output 0x00 means unmapped: discarded.
  - Push word {ctrl, shift_eff, e0, 5'b0, ascii}.
- FIFO:
  - wr_ptr and rd_ptr are ADDR_W bits and wrap modulo DEPTH; count is ADDR_W+1 bits.
  - Push accepted if count<DEPTH, or if count==DEPTH and rd_en is popping in the same cycle (count unchanged).
  - Otherwise the push is dropped and overflow is set.
  - rd_en while empty is ignored; rd_data stays 0.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
- overflow is cleared by clr_ovf. A set and a clear in the same cycle leaves overflow set.
- caps_led = caps.

## Timing
- Reset (async assert, sync-released by system): rd_data=0, kb_empty=1, kb_full=0, overflow=0, caps_led=0. Pointers, count, v1, shift_l/r, ctrl, caps, caps_held and kb_ready_d are all 0.
- Latency: kb_ready first sampled high at edge N → capture at N → push at edge N+1 → kb_empty low and rd_data valid after edge N+1.
- Pop at edge M: rd_data shows next entry (or 0) after edge M; kb_full/kb_empty update at the same edge.
- Modifier state updates at the stage-2 edge. A make arriving in the very next event uses the new state.
- Reset mid-operation: an in-flight capture is lost and the FIFO contents are discarded. No partial entry survives.

## Structure
- Shared package kb_pkg holds:
  - scancode constants: SC_LSHIFT 0x12, SC_RSHIFT 0x59, SC_CTRL 0x14, SC_CAPS 0x58, SC_E0 0xE0, SC_BREAK 0xF0;
  - arrow ASCII codes 0x80–0x83;
  - entry bit positions.
- Sub-module kb_ascii_rom: combinational lookup (code[7:0], shift) → ascii[7:0], 0x00 when unmapped.
- Top level holds the edge detector, capture register, modifier FSM and FIFO.

## Test plan
- After reset, present 0x1C make (kb_ready held 200 cycles): exactly one entry, rd_data=16'h0061; pop → kb_empty=1, rd_data=0.
- 0x12 make, 0x1C make, then 0x12 break (break flag), 0x1C make: entries 16'h4041, then 16'h0061.
- 0x58 make twice without break (repeat), then 0x58 break, then 0x1C make: caps_led=1, entry 16'h0041. 0x58 make and break again, then 0x1C make: caps_led=0, entry 16'h0061.
- E0 0x75 make → 16'h2080; E0 0x1F make and 0x1C break produce no entry.
- 17 makes of 0x29 with no pops: kb_full=1, overflow=1, 16 entries of 16'h0020. With the FIFO full, a push and pop in the same cycle keep count at 16 and leave overflow unchanged.
- Assert rst while 3 entries are queued and an event is in capture: all outputs return to reset values; the next make yields a single correct entry.
